count_step_monitor: RTL and testbench
=====================================

COUNT_STEP_MONITOR -- requirements
Module: count_step_monitor

Interface
REQ-001 Parameter CNT_W, default 8, width of each wrap counter.
REQ-002 Parameter ERR_W, default 4, width of the saturating error counter.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 z_in  input  2  count value from the upstream up/down counter.
REQ-006 dir_in  input  1  direction applied to the upstream counter: 1 = down, 0 = up.
REQ-007 valid_in  input  1  sample strobe; z_in and dir_in are sampled only when valid_in=1.
REQ-008 clr_err  input  1  clears err, err_cnt and the FAULT state.
REQ-009 wrap_up  output  1  one-cycle pulse on a legal up-wrap 3->0.
REQ-010 wrap_dn  output  1  one-cycle pulse on a legal down-wrap 0->3.
REQ-011 wrap_up_cnt  output  CNT_W  number of up-wraps, modulo 2^CNT_W.
REQ-012 wrap_dn_cnt  output  CNT_W  number of down-wraps, modulo 2^CNT_W.
REQ-013 err  output  1  sticky illegal-step flag; equals 1 exactly when state is FAULT.
REQ-014 err_cnt  output  ERR_W  illegal-step count, saturating at 2^ERR_W-1.
REQ-015 All outputs shall be registered.

Function
REQ-016 The block shall hold internal registers z_prev[1:0] and dir_prev, loaded from z_in and dir_in on every accepted sample (valid_in=1, reset=0).
REQ-017 The state machine shall have states SYNC, TRACK and FAULT.
REQ-018 SYNC: the first accepted sample loads z_prev/dir_prev, performs no step check, and moves to TRACK.
REQ-019 Step check on each accepted sample in TRACK or FAULT: expected = z_prev+1 mod 4 if dir_prev=0, z_prev-1 mod 4 if dir_prev=1.
REQ-020 z_in==z_prev (hold) shall be legal with no wrap and no counting.
REQ-021 z_in==expected shall be legal; in addition, z_prev=3 with z_in=0 and dir_prev=0 is an up-wrap, and z_prev=0 with z_in=3 and dir_prev=1 is a down-wrap.
REQ-022 Any other z_in shall be an illegal step: next state FAULT, err_cnt increments (saturating), and z_prev resynchronises to z_in.
REQ-023 On an up-wrap, wrap_up shall be 1 in the following cycle only, and wrap_up_cnt shall increment; wrap_dn/wrap_dn_cnt behave identically for down-wraps.
REQ-024 Wrap counters shall roll over from 2^CNT_W-1 to 0 without any flag.
REQ-025 Wraps shall be detected and counted in both TRACK and FAULT.
REQ-026 With valid_in=0, no register other than the wrap pulses shall change; wrap_up and wrap_dn shall be 0.
REQ-027 Step evaluation shall take effect on the cycle after the sample: one-cycle latency for every output.
REQ-028 clr_err=1 without a simultaneous illegal step: err=0, err_cnt=0, FAULT->TRACK; it shall not affect SYNC, z_prev or the wrap counters.
REQ-029 clr_err=1 with a simultaneous illegal step: the illegal step wins, giving err=1, err_cnt=1, state FAULT.
REQ-030 A change in dir_in takes effect on the next step check, because the expected value always uses dir_prev.

Reset
REQ-031 reset=1 at a clock edge shall force state to SYNC, z_prev=0, dir_prev=0, and all outputs to 0, regardless of valid_in or clr_err.
REQ-032 Reset asserted during FAULT or mid-sequence shall discard all history; the first sample after reset is not checked.

Verification
REQ-033 Up sequence: reset, then valid samples z=0,1,2,3,0,1 with dir=0 -> one wrap_up pulse one cycle after the 3->0 sample, wrap_up_cnt=1, err=0.
REQ-034 Down sequence: samples z=2,1,0,3,2 with dir=1 -> wrap_dn pulse after 0->3, wrap_dn_cnt=1, wrap_up_cnt=0.
REQ-035 Illegal step: samples z=0,1,3 with dir=0 -> err=1, err_cnt=1, state FAULT; a following z=0 counts as an up-wrap (wrap_up_cnt=1).
REQ-036 Saturation and clear: 20 illegal steps -> err_cnt=15 (ERR_W=4); clr_err -> err=0 and err_cnt=0; clr_err together with an illegal step -> err_cnt=1.
REQ-037 Rollover: 256 up-wraps -> wrap_up_cnt returns to 0 with no error.
REQ-038 Reset mid-FAULT, then first sample z=2 -> no error, and all counters remain 0.

Source files
------------

// File: rtl/count_step_monitor.sv
// ---------------------------------------------------------------------------
// count_step_monitor
//
// Watches the 2-bit output of an upstream up/down counter together with the
// direction that was applied to it. Every accepted sample is compared with the
// previous one: a hold or a single step in the previously applied direction is
// legal, and anything else is an illegal step. Legal 3->0 (up) and 0->3 (down)
// transitions are reported as wraps, and each kind is counted.
//
// Sample qualification:
//   valid_in is a one-way strobe with no back-pressure; the block is always
//   ready. z_in, dir_in and clr_err are acted on only in a cycle where
//   valid_in=1. In a cycle with valid_in=0, all state holds and the wrap
//   pulses drop to 0.
//
// Ports:
//   clk          in   clock; every register updates on its rising edge
//   reset        in   synchronous, active-high; returns to SYNC and clears all
//   z_in[1:0]    in   count value from the upstream counter
//   dir_in       in   direction applied upstream (1 = down, 0 = up)
//   valid_in     in   sample strobe
//   clr_err      in   clears err / err_cnt and leaves FAULT (loses to an
//                     illegal step in the same sample)
//   wrap_up      out  one-cycle pulse after a legal 3->0 with dir_prev=0
//   wrap_dn      out  one-cycle pulse after a legal 0->3 with dir_prev=1
//   wrap_up_cnt  out  up-wrap count, free-running modulo 2^CNT_W
//   wrap_dn_cnt  out  down-wrap count, free-running modulo 2^CNT_W
//   err          out  1 exactly while in FAULT
//   err_cnt      out  illegal-step count, saturating at 2^ERR_W-1
//   state_dbg_o  out  current FSM state (0 = SYNC, 1 = TRACK, 2 = FAULT)
//
// All outputs are registered. Each output reflects the sample taken at the
// previous clock edge.
// ---------------------------------------------------------------------------
module count_step_monitor #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       z_in,
  input  logic             dir_in,
  input  logic             valid_in,
  input  logic             clr_err,
  output logic             wrap_up,
  output logic             wrap_dn,
  output logic [CNT_W-1:0] wrap_up_cnt,
  output logic [CNT_W-1:0] wrap_dn_cnt,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       state_dbg_o
);

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  // Registered state and outputs.
  state_e           state_q;
  logic [1:0]       z_prev_q;
  logic             dir_prev_q;
  logic             wrap_up_q;
  logic             wrap_dn_q;
  logic [CNT_W-1:0] wrap_up_cnt_q;
  logic [CNT_W-1:0] wrap_dn_cnt_q;
  logic             err_q;
  logic [ERR_W-1:0] err_cnt_q;

  // Step classification of the current input against the stored sample.
  logic [1:0]       z_exp;
  logic             step_hold;
  logic             step_legal;
  logic             step_up_wrap;
  logic             step_dn_wrap;
  logic [ERR_W-1:0] err_cnt_inc;

  always_comb begin
    z_exp        = 2'd0;
    step_hold    = 1'b0;
    step_legal   = 1'b0;
    step_up_wrap = 1'b0;
    step_dn_wrap = 1'b0;
    err_cnt_inc  = err_cnt_q;

    // The expected value follows the direction stored with the previous
    // sample; a direction change on dir_in only matters for the next step.
    if (dir_prev_q) begin
      z_exp = z_prev_q - 2'd1;
    end else begin
      z_exp = z_prev_q + 2'd1;
    end

    step_hold  = (z_in == z_prev_q);
    step_legal = step_hold || (z_in == z_exp);

    // A wrap is just a legal step across the 3/0 boundary. A hold never
    // matches here because z_in differs from z_prev_q in both cases.
    step_up_wrap = !dir_prev_q && (z_prev_q == 2'd3) && (z_in == 2'd0);
    step_dn_wrap =  dir_prev_q && (z_prev_q == 2'd0) && (z_in == 2'd3);

    if (err_cnt_q != ERR_MAX) begin
      err_cnt_inc = err_cnt_q + ERR_ONE;
    end
  end

  // Single FSM process: state, history and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_SYNC;
      z_prev_q      <= 2'd0;
      dir_prev_q    <= 1'b0;
      wrap_up_q     <= 1'b0;
      wrap_dn_q     <= 1'b0;
      wrap_up_cnt_q <= '0;
      wrap_dn_cnt_q <= '0;
      err_q         <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      // Wrap indications are single-cycle pulses.
      wrap_up_q <= 1'b0;
      wrap_dn_q <= 1'b0;

      if (valid_in) begin
        // History always follows the latest accepted sample, which also
        // resynchronises tracking after an illegal step.
        z_prev_q   <= z_in;
        dir_prev_q <= dir_in;

        unique case (state_q)
          ST_SYNC: begin
            // First sample after reset only establishes history.
            state_q <= ST_TRACK;
            err_q   <= 1'b0;
          end

          ST_TRACK, ST_FAULT: begin
            if (!step_legal) begin
              // Illegal step beats a simultaneous clear: the count restarts
              // at one rather than being incremented.
              state_q <= ST_FAULT;
              err_q   <= 1'b1;
              if (clr_err) begin
                err_cnt_q <= ERR_ONE;
              end else begin
                err_cnt_q <= err_cnt_inc;
              end
            end else begin
              if (step_up_wrap) begin
                wrap_up_q     <= 1'b1;
                wrap_up_cnt_q <= wrap_up_cnt_q + CNT_ONE;
              end
              if (step_dn_wrap) begin
                wrap_dn_q     <= 1'b1;
                wrap_dn_cnt_q <= wrap_dn_cnt_q + CNT_ONE;
              end
              if (clr_err) begin
                state_q   <= ST_TRACK;
                err_q     <= 1'b0;
                err_cnt_q <= '0;
              end
            end
          end

          default: begin
            // Unreachable encoding: recover through SYNC.
            state_q <= ST_SYNC;
            err_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wrap_up     = wrap_up_q;
  assign wrap_dn     = wrap_dn_q;
  assign wrap_up_cnt = wrap_up_cnt_q;
  assign wrap_dn_cnt = wrap_dn_cnt_q;
  assign err         = err_q;
  assign err_cnt     = err_cnt_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_count_step_monitor.sv
// ---------------------------------------------------------------------------
// tb_count_step_monitor
//
// Table-driven directed vectors, hand-written multi-cycle sequences
// (saturation/clear, rollover) and randomized traffic checked against a
// behavioural model that works from the step rules using integer arithmetic.
// ---------------------------------------------------------------------------
module tb_count_step_monitor;

  localparam int CNT_W = 8;
  localparam int ERR_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam int ERR_SAT = (1 << ERR_W) - 1;

  localparam int S_SYNC  = 0;
  localparam int S_TRACK = 1;
  localparam int S_FAULT = 2;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       z_in = 2'd0;
  logic             dir_in = 1'b0;
  logic             valid_in = 1'b0;
  logic             clr_err = 1'b0;
  logic             wrap_up;
  logic             wrap_dn;
  logic [CNT_W-1:0] wrap_up_cnt;
  logic [CNT_W-1:0] wrap_dn_cnt;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0]       state_dbg_o;

  always #5 clk = ~clk;

  count_step_monitor #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .z_in        (z_in),
    .dir_in      (dir_in),
    .valid_in    (valid_in),
    .clr_err     (clr_err),
    .wrap_up     (wrap_up),
    .wrap_dn     (wrap_dn),
    .wrap_up_cnt (wrap_up_cnt),
    .wrap_dn_cnt (wrap_dn_cnt),
    .err         (err),
    .err_cnt     (err_cnt),
    .state_dbg_o (state_dbg_o)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // History is "the last accepted sample"; a step is legal when the new value
  // equals the old one or lies one position away in the stored direction.
  bit m_have_prev;
  int m_zp, m_dp;
  bit m_fault;
  int m_ecnt, m_ucnt, m_dcnt;
  bit m_pu, m_pd;

  task automatic model_step(input bit rst, input bit v, input int z, input bit d, input bit clr);
    int nxt;
    m_pu = 0;
    m_pd = 0;
    if (rst) begin
      m_have_prev = 0; m_zp = 0; m_dp = 0; m_fault = 0;
      m_ecnt = 0; m_ucnt = 0; m_dcnt = 0;
      return;
    end
    if (!v) return;
    if (m_have_prev) begin
      nxt = m_dp ? (m_zp + 3) % 4 : (m_zp + 1) % 4;
      if (z != m_zp && z != nxt) begin
        m_fault = 1;
        m_ecnt  = clr ? 1 : ((m_ecnt + 1 > ERR_SAT) ? ERR_SAT : m_ecnt + 1);
      end else begin
        if (z == nxt && m_dp == 0 && m_zp == 3) begin
          m_pu = 1; m_ucnt = (m_ucnt + 1) % CNT_MOD;
        end
        if (z == nxt && m_dp == 1 && m_zp == 0) begin
          m_pd = 1; m_dcnt = (m_dcnt + 1) % CNT_MOD;
        end
        if (clr) begin
          m_fault = 0; m_ecnt = 0;
        end
      end
    end
    m_have_prev = 1;
    m_zp = z;
    m_dp = d;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".wrap_up"},     wrap_up,     m_pu);
    chk({tag, ".wrap_dn"},     wrap_dn,     m_pd);
    chk({tag, ".err"},         err,         m_fault);
    chk({tag, ".err_cnt"},     err_cnt,     m_ecnt);
    chk({tag, ".wrap_up_cnt"}, wrap_up_cnt, m_ucnt);
    chk({tag, ".wrap_dn_cnt"}, wrap_dn_cnt, m_dcnt);
    chk({tag, ".state"},       state_dbg_o, !m_have_prev ? S_SYNC : (m_fault ? S_FAULT : S_TRACK));
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, lets the edge happen, then samples 1 ns later.
  task automatic apply(input bit rst, input bit v, input int z, input bit d, input bit clr);
    reset    = rst;
    valid_in = v;
    z_in     = 2'(z);
    dir_in   = d;
    clr_err  = clr;
    @(posedge clk);
    model_step(rst, v, z, d, clr);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rst; bit v; int z; bit d; bit clr;
    int up; int dn; int er; int ecnt; int ucnt; int dcnt; int st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, bit v, int z, bit d, bit clr,
                              int up, int dn, int er, int ecnt, int ucnt, int dcnt, int st);
    vec_t r;
    r.rst = rst; r.v = v; r.z = z; r.d = d; r.clr = clr;
    r.up = up; r.dn = dn; r.er = er; r.ecnt = ecnt; r.ucnt = ucnt; r.dcnt = dcnt; r.st = st;
    return r;
  endfunction

  initial begin
    int p;

    //            rst v z d clr  up dn er ec uc dc st
    // up sequence 0,1,2,3,0,1
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,S_SYNC));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,0,0,S_TRACK));
    tbl.push_back(mk(0,1,1,0,0, 0,0,0,0,0,0,S_TRACK));
    tbl.push_back(mk(0,1,2,0,0, 0,0,0,0,0,0,S_TRACK));
    tbl.push_back(mk(0,1,3,0,0, 0,0,0,0,0,0,S_TRACK));
    tbl.push_back(mk(0,1,0,0,0, 1,0,0,0,1,0,S_TRACK));
    tbl.push_back(mk(0,1,1,0,0, 0,0,0,0,1,0,S_TRACK));
    tbl.push_back(mk(0,0,3,0,0, 0,0,0,0,1,0,S_TRACK)); // idle: z ignored
    // down sequence 2,1,0,3,2
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,S_SYNC));
    tbl.push_back(mk(0,1,2,1,0, 0,0,0,0,0,0,S_TRACK));
    tbl.push_back(mk(0,1,1,1,0, 0,0,0,0,0,0,S_TRACK));
    tbl.push_back(mk(0,1,0,1,0, 0,0,0,0,0,0,S_TRACK));
    tbl.push_back(mk(0,1,3,1,0, 0,1,0,0,0,1,S_TRACK));
    tbl.push_back(mk(0,1,2,1,0, 0,0,0,0,0,1,S_TRACK));
    // illegal step 0,1,3 then wrap in FAULT, clear, clear+illegal
    tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,S_SYNC));
    tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,0,0,S_TRACK));
    tbl.push_back(mk(0,1,1,0,0, 0,0,0,0,0,0,S_TRACK));
    tbl.push_back(mk(0,1,3,0,0, 0,0,1,1,0,0,S_FAULT));
    tbl.push_back(mk(0,1,0,0,0, 1,0,1,1,1,0,S_FAULT));
    tbl.push_back(mk(0,1,0,0,1, 0,0,0,0,1,0,S_TRACK));
    tbl.push_back(mk(0,1,2,0,1, 0,0,1,1,1,0,S_FAULT));
    // reset mid-FAULT (with valid and clr high), first sample z=2 unchecked
    tbl.push_back(mk(1,1,1,0,1, 0,0,0,0,0,0,S_SYNC));
    tbl.push_back(mk(0,1,2,0,0, 0,0,0,0,0,0,S_TRACK));
    tbl.push_back(mk(0,1,3,0,0, 0,0,0,0,0,0,S_TRACK));
    // direction change takes effect one sample later
    tbl.push_back(mk(0,1,3,1,0, 0,0,0,0,0,0,S_TRACK));
    tbl.push_back(mk(0,1,2,1,0, 0,0,0,0,0,0,S_TRACK));
    tbl.push_back(mk(0,1,3,0,0, 0,0,1,1,0,0,S_FAULT));
    tbl.push_back(mk(0,0,1,0,0, 0,0,1,1,0,0,S_FAULT));

    apply(1, 0, 0, 0, 0);
    foreach (tbl[i]) begin
      string tag;
      apply(tbl[i].rst, tbl[i].v, tbl[i].z, tbl[i].d, tbl[i].clr);
      tag = $sformatf("row%0d", i);
      chk({tag, ".wrap_up"},     wrap_up,     tbl[i].up);
      chk({tag, ".wrap_dn"},     wrap_dn,     tbl[i].dn);
      chk({tag, ".err"},         err,         tbl[i].er);
      chk({tag, ".err_cnt"},     err_cnt,     tbl[i].ecnt);
      chk({tag, ".wrap_up_cnt"}, wrap_up_cnt, tbl[i].ucnt);
      chk({tag, ".wrap_dn_cnt"}, wrap_dn_cnt, tbl[i].dcnt);
      chk({tag, ".state"},       state_dbg_o, tbl[i].st);
    end

    // ---------------- saturation and clear ----------------
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0);
    p = 0;
    for (int i = 0; i < 20; i++) begin
      p = (p + 2) % 4;                 // two steps away: always illegal
      apply(0, 1, p, 0, 0);
    end
    chk("sat.err_cnt", err_cnt, 15);
    chk("sat.err", err, 1);
    check_model("sat");
    apply(0, 1, p, 0, 1);              // hold + clear
    chk("clr.err", err, 0);
    chk("clr.err_cnt", err_cnt, 0);
    chk("clr.state", state_dbg_o, S_TRACK);
    apply(0, 1, (p + 2) % 4, 0, 1);    // illegal + clear
    chk("clr_ill.err", err, 1);
    chk("clr_ill.err_cnt", err_cnt, 1);
    chk("clr_ill.state", state_dbg_o, S_FAULT);

    // ---------------- wrap counter rollover ----------------
    apply(1, 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0);
    for (int w = 0; w < 256; w++) begin
      for (int k = 1; k <= 4; k++) apply(0, 1, k % 4, 0, 0);
      if (w == 254) chk("roll.cnt255", wrap_up_cnt, 255);
    end
    chk("roll.wrap_up_cnt", wrap_up_cnt, 0);
    chk("roll.err", err, 0);
    chk("roll.err_cnt", err_cnt, 0);
    chk("roll.wrap_dn_cnt", wrap_dn_cnt, 0);
    check_model("roll");

    // ---------------- randomized traffic vs model ----------------
    apply(1, 0, 0, 0, 0);
    check_model("rnd_rst");
    for (int i = 0; i < 600; i++) begin
      bit r, v, d, c;
      int z;
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      c = v && ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 0) begin
        // bias towards legal moves so wraps occur often
        z = dir_in ? (32'(z_in) + 3) % 4 : (32'(z_in) + 1) % 4;
        d = ($urandom_range(0, 7) == 0) ? !dir_in : dir_in;
      end else begin
        z = $urandom_range(0, 3);
        d = $urandom_range(0, 1);
      end
      apply(r, v, z, d, c);
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
